// File: rtl/register_file_pkg.sv
// register_file_pkg
//   Shared processor definitions used by the register file and the
//   execution datapath around it.
//   Contents:
//     XLEN       default architectural data width
//     REG_AW     register address width (log2 of the 32-entry ABI space)
//     REG_ZERO   ABI index of the hardwired-zero register x0
//     REG_SP     ABI index of the stack pointer x2
//     alu_op_t   ALU operation encodings ({funct7[5], funct3} style)
//     alu_eval   reference ALU evaluation on two operands
package register_file_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_SP   = 5'd2;

  // Bit 3 selects the alternate form (SUB / SRA) of the base operation.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  localparam int SHAMT_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] alu_eval(
    input alu_op_t         op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SHAMT_W-1:0]     shamt;
    logic [XLEN-1:0]        res;
    sa    = $signed(a);
    sb    = $signed(b);
    shamt = b[SHAMT_W-1:0];
    res   = '0;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_SLL:  res = a << shamt;
      ALU_SRL:  res = a >> shamt;
      ALU_SRA:  res = $unsigned(sa >>> shamt);
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, (sa < sb)};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  res = a ^ b;
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/register_file.sv
// register_file
//   Architectural integer register file: two operand read ports, one debug
//   read port and a single write port. x0 is hardwired to zero and has no
//   storage; x2 (stack pointer) resets to SP_INIT, everything else to 0.
//   Parameters:
//     XLEN     data width of every register and data port
//     NREGS    number of architectural registers (x0 included)
//     SP_INIT  reset value of x2
//     BYPASS   1 forwards the in-flight write data to rs1/rs2 reads
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     rs1_addr   read port 1 address  -> rs1_data (ALU operand A)
//     rs2_addr   read port 2 address  -> rs2_data (ALU operand B)
//     reg_write  write enable
//     rd_addr    write address
//     rd_data    write data (ALU result or load data)
//     dbg_addr   debug read address   -> dbg_data (never forwarded)
module register_file #(
  parameter int                            XLEN    = register_file_pkg::XLEN,
  parameter int                            NREGS   = 32,
  parameter logic [XLEN-1:0]               SP_INIT = 32'h0000_0FFC,
  parameter bit                            BYPASS  = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [register_file_pkg::REG_AW-1:0] rs1_addr,
  input  logic [register_file_pkg::REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]                  rs1_data,
  output logic [XLEN-1:0]                  rs2_data,
  input  logic                             reg_write,
  input  logic [register_file_pkg::REG_AW-1:0] rd_addr,
  input  logic [XLEN-1:0]                  rd_data,
  input  logic [register_file_pkg::REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]                  dbg_data
);

  import register_file_pkg::*;

  // NREGS widened by one bit so it can be compared against a full address.
  localparam logic [REG_AW:0] NREGS_W = (REG_AW+1)'(NREGS);

  // x0 has no storage; entries 1..NREGS-1 hold x1..x(NREGS-1).
  logic [XLEN-1:0] regs [1:NREGS-1];

  // An address names real storage only if it is nonzero and inside NREGS;
  // everything else reads as zero and ignores writes.
  function automatic logic has_storage(input logic [REG_AW-1:0] addr);
    return (addr != REG_ZERO) && ({1'b0, addr} < NREGS_W);
  endfunction

  logic wr_qual;
  assign wr_qual = reg_write && has_storage(rd_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
      end
    end else if (wr_qual) begin
      regs[rd_addr] <= rd_data;
    end
  end

  // Forwarding is suppressed during reset so reads show the reset image.
  logic fwd_rs1;
  logic fwd_rs2;
  assign fwd_rs1 = BYPASS && !rst && wr_qual && (rs1_addr == rd_addr);
  assign fwd_rs2 = BYPASS && !rst && wr_qual && (rs2_addr == rd_addr);

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    dbg_data = '0;
    if (has_storage(rs1_addr)) rs1_data = regs[rs1_addr];
    if (has_storage(rs2_addr)) rs2_data = regs[rs2_addr];
    if (has_storage(dbg_addr)) dbg_data = regs[dbg_addr];
    if (fwd_rs1) rs1_data = rd_data;
    if (fwd_rs2) rs2_data = rd_data;
  end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
  import register_file_pkg::*;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        reg_write = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data = '0;
  logic [4:0]  dbg_addr = '0;

  logic [31:0] rs1_data_nb, rs2_data_nb, dbg_data_nb;
  logic [31:0] rs1_data_bp, rs2_data_bp, dbg_data_bp;

  int tests_run = 0;
  int tests_failed = 0;

  register_file #(.XLEN(32), .NREGS(32), .SP_INIT(32'h0000_0FFC), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data_nb), .rs2_data(rs2_data_nb),
    .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
  );

  register_file #(.XLEN(32), .NREGS(32), .SP_INIT(32'h0000_0FFC), .BYPASS(1'b1)) dut_bp (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data_bp), .rs2_data(rs2_data_bp),
    .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_bp)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a write at the falling edge, let one rising edge take it, then drop it.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_write = 1'b1;
    rd_addr   = a;
    rd_data   = d;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
  endtask

  initial begin
    // Reset with the clock stopped.
    rs1_addr = 5'd5; rs2_addr = 5'd2; dbg_addr = 5'd31;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_rs1_x5", rs1_data_nb, 32'h0);
    check_eq("rst_rs2_x2", rs2_data_nb, 32'h0000_0FFC);
    check_eq("rst_dbg_x31", dbg_data_nb, 32'h0);
    check_eq("rst_rs2_x2_bp", rs2_data_bp, 32'h0000_0FFC);

    // Edges during reset with a write pending must be discarded.
    reg_write = 1'b1; rd_addr = 5'd3; rd_data = 32'hCAFE_0003;
    rs1_addr = 5'd3;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_bp_suppressed", rs1_data_bp, 32'h0);
    @(negedge clk);
    reg_write = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_x3", rs1_data_nb, 32'h0);
    check_eq("post_rst_x2", rs2_data_nb, 32'h0000_0FFC);

    // Write/read into the ALU operands.
    do_write(5'd5, 32'h0000_000A);
    do_write(5'd6, 32'hFFFF_FFF6);
    @(negedge clk);
    rs1_addr = 5'd5; rs2_addr = 5'd6;
    #1;
    check_eq("rd_x5", rs1_data_nb, 32'h0000_000A);
    check_eq("rd_x6", rs2_data_nb, 32'hFFFF_FFF6);
    check_eq("alu_add", alu_eval(ALU_ADD, rs1_data_nb, rs2_data_nb), 32'h0);
    check_eq("alu_sub", alu_eval(ALU_SUB, rs1_data_nb, rs2_data_nb), 32'h0000_0014);

    // Identical addresses on both ports.
    rs1_addr = 5'd6; rs2_addr = 5'd6;
    #1;
    check_eq("same_addr_rs1", rs1_data_nb, 32'hFFFF_FFF6);
    check_eq("same_addr_rs2", rs2_data_nb, 32'hFFFF_FFF6);

    // x0 protection.
    do_write(5'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    rs1_addr = 5'd0; dbg_addr = 5'd0;
    #1;
    check_eq("x0_rs1", rs1_data_nb, 32'h0);
    check_eq("x0_dbg", dbg_data_nb, 32'h0);

    // Disabled write changes nothing.
    @(negedge clk);
    reg_write = 1'b0; rd_addr = 5'd5; rd_data = 32'h1111_1111;
    @(posedge clk); #1;
    rs1_addr = 5'd5;
    #1;
    check_eq("we0_hold_x5", rs1_data_nb, 32'h0000_000A);

    // Same-cycle hazard, with and without forwarding.
    do_write(5'd7, 32'h0000_0001);
    @(negedge clk);
    rs1_addr = 5'd7; dbg_addr = 5'd7; rs2_addr = 5'd0;
    reg_write = 1'b1; rd_addr = 5'd7; rd_data = 32'h0000_0055;
    #1;
    check_eq("haz_nb_before", rs1_data_nb, 32'h0000_0001);
    check_eq("haz_bp_before", rs1_data_bp, 32'h0000_0055);
    check_eq("haz_bp_dbg", dbg_data_bp, 32'h0000_0001);
    @(posedge clk); #1;
    reg_write = 1'b0;
    #1;
    check_eq("haz_nb_after", rs1_data_nb, 32'h0000_0055);

    // Address 0 is never forwarded.
    @(negedge clk);
    reg_write = 1'b1; rd_addr = 5'd0; rd_data = 32'h0BAD_F00D;
    rs1_addr = 5'd0;
    #1;
    check_eq("bp_x0", rs1_data_bp, 32'h0);
    @(posedge clk); #1;
    reg_write = 1'b0;

    // Reset asserted between edges, write attempted while held.
    do_write(5'd9, 32'h0000_1234);
    @(negedge clk);
    rs1_addr = 5'd9; rs2_addr = 5'd2;
    #1;
    check_eq("x9_written", rs1_data_nb, 32'h0000_1234);
    #1 rst = 1'b1;
    #1;
    check_eq("x9_async_rst", rs1_data_nb, 32'h0);
    check_eq("sp_async_rst", rs2_data_nb, 32'h0000_0FFC);
    reg_write = 1'b1; rd_addr = 5'd10; rd_data = 32'h0000_0077;
    @(posedge clk);
    @(negedge clk);
    reg_write = 1'b0;
    rst = 1'b0;
    rs1_addr = 5'd10;
    @(posedge clk); #1;
    check_eq("x10_discarded", rs1_data_nb, 32'h0);
    do_write(5'd10, 32'h0000_0077);
    #1;
    check_eq("x10_after_rel", rs1_data_nb, 32'h0000_0077);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
